// File: rtl/fp_add_collect.sv
// Result collector behind fp_add: packs, classifies and buffers each result in a
// first-word-fall-through FIFO, dropping (and counting) arrivals that find it full.
module fp_add_collect #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dst_valid,
  input  logic [22:0]              r_man,
  input  logic [7:0]               r_exp,
  input  logic                     r_sign,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // {nan, inf, zero}; denormals and finite normals set nothing
  function automatic logic [2:0] classify(input logic [7:0] e, input logic [22:0] m);
    logic man_nz;
    logic exp_max;
    logic exp_zero;
    man_nz   = |m;
    exp_max  = &e;
    exp_zero = ~(|e);
    return {exp_max & man_nz, exp_max & ~man_nz, exp_zero & ~man_nz};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [34:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_vld;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [34:0]      w_entry_p0;

  assign w_vld      = (r_level != '0);
  assign w_full     = (r_level == FULL);
  assign w_pop      = w_vld & out_ready;
  assign w_push     = dst_valid & (~w_full | w_pop);
  assign w_drop     = dst_valid & w_full & ~w_pop;
  assign w_entry_p0 = {classify(r_exp, r_man), r_sign, r_exp, r_man};

  // p0 -> storage: payload only, never reset
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= w_entry_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // a drop in the same cycle as a clear wins and restarts the count at 1
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= clr_ovf ? CNT_W'(1) : sat_inc(r_drop_cnt);
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  // storage -> consumer: head shown only while valid
  assign out_valid = w_vld;
  assign out_data  = w_vld ? r_mem[r_rd_ptr][31:0]  : 32'h0;
  assign out_flags = w_vld ? r_mem[r_rd_ptr][34:32] : 3'b000;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_fp_add_collect.sv
// Bench for fp_add_collect: scenario tasks with a queue scoreboard of expected
// {flags, word} entries, filled as pushes are driven and drained from the head.
module tb_fp_add_collect;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             dst_valid;
  logic [22:0]      r_man;
  logic [7:0]       r_exp;
  logic             r_sign;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [2:0]       out_flags;
  logic [3:0]       level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic             clr_ovf;

  int total = 0;
  int bad   = 0;
  logic [34:0] sb[$];

  always #5 clk = ~clk;

  fp_add_collect #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .dst_valid(dst_valid), .r_man(r_man), .r_exp(r_exp),
    .r_sign(r_sign), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  // One clock of stimulus; the expected entry is queued only if the FIFO can take it.
  task automatic step(input logic dv, input logic [31:0] w, input logic [2:0] f,
                      input logic rdy, input logic clr);
    bit pop;
    bit push;
    dst_valid = dv;
    r_sign    = w[31];
    r_exp     = w[30:23];
    r_man     = w[22:0];
    out_ready = rdy;
    clr_ovf   = clr;
    pop  = (sb.size() != 0) && rdy;
    push = dv && ((sb.size() < DEPTH) || pop);
    if (pop)  void'(sb.pop_front());
    if (push) sb.push_back({f, w});
    @(posedge clk);
    #1;
    dst_valid = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (level !== 4'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_flags !== 3'b000 ||
        overflow !== 1'b0 || drop_cnt !== '0) begin
      bad++;
      $display("FAIL reset: level=%0d vld=%b data=%h flags=%b ovf=%b cnt=%0d, required all zero",
               level, out_valid, out_data, out_flags, overflow, drop_cnt);
    end
  endtask

  task automatic test_pass_through();
    step(1'b1, 32'h3F800000, 3'b000, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== sb[0][31:0] || out_flags !== sb[0][34:32] || level !== 4'd1) begin
      bad++;
      $display("FAIL pass_head: vld=%b data=%h flags=%b level=%0d, required 1 3f800000 000 1",
               out_valid, out_data, out_flags, level);
    end
    step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0 || level !== 4'd0 || out_data !== 32'h0) begin
      bad++;
      $display("FAIL pass_empty: vld=%b level=%0d data=%h, required 0 0 0", out_valid, level, out_data);
    end
  endtask

  task automatic test_classify();
    step(1'b1, 32'h80000000, 3'b001, 1'b0, 1'b0);
    step(1'b1, 32'h7F800000, 3'b010, 1'b0, 1'b0);
    step(1'b1, 32'h7F800001, 3'b100, 1'b0, 1'b0);
    step(1'b1, 32'h00000005, 3'b000, 1'b0, 1'b0);
    total++;
    if (level !== 4'd4) begin
      bad++;
      $display("FAIL class_level: got %0d, required 4", level);
    end
    for (int k = 0; k < DEPTH + 2 && sb.size() != 0; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== sb[0][31:0] || out_flags !== sb[0][34:32]) begin
        bad++;
        $display("FAIL class_drain[%0d]: vld=%b data=%h flags=%b, required 1 %h %b",
                 k, out_valid, out_data, out_flags, sb[0][31:0], sb[0][34:32]);
      end
      step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    end
    total++;
    if (out_valid !== 1'b0 || out_flags !== 3'b000) begin
      bad++;
      $display("FAIL class_empty: vld=%b flags=%b, required 0 000", out_valid, out_flags);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++)
      step(1'b1, {9'h0, 23'(i)}, (i == 0) ? 3'b001 : 3'b000, 1'b0, 1'b0);
    total++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 16'd2) begin
      bad++;
      $display("FAIL ovf_state: level=%0d ovf=%b cnt=%0d, required 8 1 2", level, overflow, drop_cnt);
    end
    for (int k = 0; k < DEPTH + 2 && sb.size() != 0; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== sb[0][31:0] || out_flags !== sb[0][34:32]) begin
        bad++;
        $display("FAIL ovf_drain[%0d]: vld=%b data=%h flags=%b, required 1 %h %b",
                 k, out_valid, out_data, out_flags, sb[0][31:0], sb[0][34:32]);
      end
      step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    end
    total++;
    if (out_valid !== 1'b0 || level !== 4'd0 || drop_cnt !== 16'd2) begin
      bad++;
      $display("FAIL ovf_empty: vld=%b level=%0d cnt=%0d, required 0 0 2", out_valid, level, drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, {9'h0, 23'(20 + i)}, 3'b000, 1'b0, 1'b0);
    step(1'b1, {9'h0, 23'd100}, 3'b000, 1'b1, 1'b0);
    total++;
    if (level !== 4'd8 || drop_cnt !== 16'd2) begin
      bad++;
      $display("FAIL full_pp: level=%0d cnt=%0d, required 8 2", level, drop_cnt);
    end
    for (int k = 0; k < DEPTH + 2 && sb.size() != 0; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== sb[0][31:0]) begin
        bad++;
        $display("FAIL full_drain[%0d]: vld=%b data=%h, required 1 %h", k, out_valid, out_data, sb[0][31:0]);
      end
      step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_empty: vld=%b, required 0", out_valid);
    end
  endtask

  task automatic test_clear_vs_drop();
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++)
      step(1'b1, {9'h0, 23'(40 + i)}, 3'b000, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd3) begin
      bad++;
      $display("FAIL clr_pre: ovf=%b cnt=%0d, required 1 3", overflow, drop_cnt);
    end
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL clr_only: ovf=%b cnt=%0d, required 0 0", overflow, drop_cnt);
    end
    step(1'b1, {9'h0, 23'd77}, 3'b000, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd1 || level !== 4'd8) begin
      bad++;
      $display("FAIL clr_drop: ovf=%b cnt=%0d level=%0d, required 1 1 8", overflow, drop_cnt, level);
    end
  endtask

  task automatic test_reset_midstream();
    // FIFO is full with overflow set; drain to 5 entries first
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    total++;
    if (level !== 4'd5 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: level=%0d ovf=%b, required 5 1", level, overflow);
    end
    rst       = 1'b1;
    dst_valid = 1'b1;
    r_sign    = 1'b0;
    r_exp     = 8'h80;
    r_man     = 23'h1234;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    dst_valid = 1'b0;
    sb.delete();
    total++;
    if (level !== 4'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || overflow !== 1'b0 || drop_cnt !== '0) begin
      bad++;
      $display("FAIL mid_rst: level=%0d vld=%b data=%h ovf=%b cnt=%0d, required 0 0 0 0 0",
               level, out_valid, out_data, overflow, drop_cnt);
    end
    step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    total++;
    if (level !== 4'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: level=%0d vld=%b, required 0 0", level, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'h40000000, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {1'b1, 8'h81, 23'(i + 1)}, 3'b000, 1'b1, 1'b0);
      total++;
      if (level !== 4'd1 || out_data !== sb[0][31:0]) begin
        bad++;
        $display("FAIL b2b[%0d]: level=%0d data=%h, required 1 %h", i, level, out_data, sb[0][31:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; dst_valid = 1'b0; r_man = '0; r_exp = '0; r_sign = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    test_reset();
    test_pass_through();
    test_classify();
    test_overflow();
    test_full_push_pop();
    test_clear_vs_drop();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
